// File: rtl/password_job_controller.sv
// Job controller for the brute-force cracking array: loads and checks a password
// frame, starts all cracker lanes, watches found/done flags and returns one result record.
module password_job_controller #(
    parameter int NUM_CHARS = 4,
    parameter int NUM_LANES = 9,
    parameter int CYCLE_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    input  logic                   in_last,
    output logic [NUM_CHARS*8-1:0] password_to_crack,
    output logic                   lane_start,
    output logic                   lane_abort,
    input  logic [NUM_LANES-1:0]   lane_found,
    input  logic [NUM_LANES-1:0]   lane_done,
    output logic                   busy,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic                   result_found,
    output logic                   result_err,
    output logic [3:0]             result_lane,
    output logic [CYCLE_W-1:0]     result_cycles
);

    // Byte count saturates one past NUM_CHARS so an over-long frame never wraps back to "exact".
    localparam int CNT_W = $clog2(NUM_CHARS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_CHARS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_CHARS + 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, REPORT} state_e;

    state_e                 state_q, state_d;
    logic [NUM_CHARS*8-1:0] pwd_q, pwd_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   bad_q, bad_d;
    logic [CYCLE_W-1:0]     cyc_q, cyc_d;
    logic                   res_found_q, res_found_d;
    logic                   res_err_q, res_err_d;
    logic [3:0]             res_lane_q, res_lane_d;
    logic [CYCLE_W-1:0]     res_cycles_q, res_cycles_d;

    logic               xfer;
    logic [CNT_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt_inc;
    logic               bad_acc;
    logic               frame_bad;
    logic               any_found;
    logic               all_done;
    logic [CYCLE_W-1:0] cyc_inc;

    function automatic logic is_pw_char(input logic [7:0] b);
        is_pw_char = (b >= 8'h30 && b <= 8'h39) || (b >= 8'h61 && b <= 8'h7A);
    endfunction

    function automatic logic [3:0] lowest_set(input logic [NUM_LANES-1:0] v);
        lowest_set = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = 4'(i);
        end
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pwd_q        <= '0;
            cnt_q        <= '0;
            bad_q        <= 1'b0;
            cyc_q        <= '0;
            res_found_q  <= 1'b0;
            res_err_q    <= 1'b0;
            res_lane_q   <= '0;
            res_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            pwd_q        <= pwd_d;
            cnt_q        <= cnt_d;
            bad_q        <= bad_d;
            cyc_q        <= cyc_d;
            res_found_q  <= res_found_d;
            res_err_q    <= res_err_d;
            res_lane_q   <= res_lane_d;
            res_cycles_q <= res_cycles_d;
        end
    end

    // A byte taken in IDLE is character 0 of a fresh frame, so stale count/bad are ignored there.
    always_comb begin
        xfer      = in_valid && in_ready;
        idx       = (state_q == IDLE) ? '0 : cnt_q;
        cnt_inc   = (idx == CNT_MAX) ? idx : idx + CNT_W'(1);
        bad_acc   = ((state_q == IDLE) ? 1'b0 : bad_q) | (idx >= CNT_FULL) | !is_pw_char(in_data);
        frame_bad = bad_acc | (cnt_inc != CNT_FULL);
        any_found = |lane_found;
        all_done  = &lane_done;
        cyc_inc   = (&cyc_q) ? cyc_q : cyc_q + CYCLE_W'(1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, LOAD: begin
                if (xfer) begin
                    if (in_last) state_d = frame_bad ? REPORT : START;
                    else         state_d = LOAD;
                end
            end
            START:   state_d = RUN;
            RUN:     if (any_found || all_done) state_d = REPORT;
            REPORT:  if (result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pwd_d        = pwd_q;
        cnt_d        = cnt_q;
        bad_d        = bad_q;
        cyc_d        = cyc_q;
        res_found_d  = res_found_q;
        res_err_d    = res_err_q;
        res_lane_d   = res_lane_q;
        res_cycles_d = res_cycles_q;
        case (state_q)
            IDLE, LOAD: begin
                if (xfer) begin
                    for (int i = 0; i < NUM_CHARS; i++) begin
                        if (idx == CNT_W'(i)) pwd_d[(NUM_CHARS-1-i)*8 +: 8] = in_data;
                    end
                    cnt_d = cnt_inc;
                    bad_d = bad_acc;
                    if (in_last && frame_bad) begin
                        res_found_d  = 1'b0;
                        res_err_d    = 1'b1;
                        res_lane_d   = '0;
                        res_cycles_d = '0;
                    end
                end
            end
            START: cyc_d = '0;
            RUN: begin
                cyc_d = cyc_inc;
                // Found takes priority over all-done when both land in the same cycle.
                if (any_found) begin
                    res_found_d  = 1'b1;
                    res_err_d    = 1'b0;
                    res_lane_d   = lowest_set(lane_found);
                    res_cycles_d = cyc_inc;
                end else if (all_done) begin
                    res_found_d  = 1'b0;
                    res_err_d    = 1'b0;
                    res_lane_d   = '0;
                    res_cycles_d = cyc_inc;
                end
            end
            REPORT: begin
                if (result_ready) begin
                    cnt_d = '0;
                    bad_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready          = (state_q == IDLE) || (state_q == LOAD);
        lane_start        = (state_q == START);
        lane_abort        = (state_q == REPORT);
        result_valid      = (state_q == REPORT);
        busy              = (state_q != IDLE);
        password_to_crack = pwd_q;
        result_found      = res_found_q;
        result_err        = res_err_q;
        result_lane       = res_lane_q;
        result_cycles     = res_cycles_q;
    end

endmodule

// File: tb/tb_password_job_controller.sv
// Scoreboard bench for password_job_controller: expected result records are queued
// as each job is driven and compared when the controller presents its result.
module tb_password_job_controller;
    localparam int NC = 4;
    localparam int NL = 9;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = '0;
    logic          in_last = 1'b0;
    logic [NC*8-1:0] password_to_crack;
    logic          lane_start;
    logic          lane_abort;
    logic [NL-1:0] lane_found = '0;
    logic [NL-1:0] lane_done = '0;
    logic          busy;
    logic          result_valid;
    logic          result_ready = 1'b0;
    logic          result_found;
    logic          result_err;
    logic [3:0]    result_lane;
    logic [CW-1:0] result_cycles;

    typedef struct {
        logic          found;
        logic          err;
        logic [3:0]    lane;
        logic [CW-1:0] cycles;
    } res_t;

    res_t exp_q[$];
    res_t e;
    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    password_job_controller #(.NUM_CHARS(NC), .NUM_LANES(NL), .CYCLE_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .password_to_crack(password_to_crack),
        .lane_start(lane_start), .lane_abort(lane_abort),
        .lane_found(lane_found), .lane_done(lane_done),
        .busy(busy),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_found(result_found), .result_err(result_err),
        .result_lane(result_lane), .result_cycles(result_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (lane_start) start_cnt <= start_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives n bytes back to back (first byte = MS byte of data); controller must be ready.
    task automatic send_frame(input logic [63:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = data[(n-1-i)*8 +: 8];
            in_last  = (i == n - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic accept_result(input string name);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        checks++;
        if ({result_valid, lane_abort, in_ready, busy} !== 4'b0010) begin
            errors++;
            $display("FAIL %s_release valid/abort/ready/busy got %b want 0010", name,
                     {result_valid, lane_abort, in_ready, busy});
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({lane_start, lane_abort, busy, result_valid, result_found, result_err, result_lane,
             result_cycles, password_to_crack} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got start=%b abort=%b busy=%b rv=%b f=%b e=%b l=%0d c=%0d pw=%h want all 0",
                     lane_start, lane_abort, busy, result_valid, result_found, result_err,
                     result_lane, result_cycles, password_to_crack);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_match();
        int s0;
        exp_q.push_back('{found: 1'b1, err: 1'b0, lane: 4'd2, cycles: 32'd17});
        s0 = start_cnt;
        send_frame(64'h6162337A, 4);
        checks++;
        if ({lane_start, password_to_crack} !== {1'b1, 32'h6162337A}) begin
            errors++;
            $display("FAIL match_start start=%b pw=%h want 1 6162337a", lane_start, password_to_crack);
        end
        repeat (17) tick();
        lane_found = 9'b000000100;
        tick();
        lane_found = '0;
        e = exp_q.pop_front();
        checks++;
        if ({result_valid, lane_abort, result_found, result_err, result_lane, result_cycles} !==
            {1'b1, 1'b1, e.found, e.err, e.lane, e.cycles}) begin
            errors++;
            $display("FAIL match_result rv=%b ab=%b f=%b e=%b l=%0d c=%0d want 1 1 %b %b %0d %0d",
                     result_valid, lane_abort, result_found, result_err, result_lane, result_cycles,
                     e.found, e.err, e.lane, e.cycles);
        end
        checks++;
        if (start_cnt - s0 !== 1) begin
            errors++;
            $display("FAIL match_start_pulses got %0d want 1", start_cnt - s0);
        end
        accept_result("match");
    endtask

    task automatic test_exhausted();
        exp_q.push_back('{found: 1'b0, err: 1'b0, lane: 4'd0, cycles: 32'd5});
        send_frame(64'h7A7A3039, 4);
        repeat (5) tick();
        lane_done = '1;
        tick();
        lane_done = '0;
        e = exp_q.pop_front();
        checks++;
        if ({result_valid, result_found, result_err, result_lane, result_cycles} !==
            {1'b1, e.found, e.err, e.lane, e.cycles}) begin
            errors++;
            $display("FAIL exhausted_result rv=%b f=%b e=%b l=%0d c=%0d want 1 %b %b %0d %0d",
                     result_valid, result_found, result_err, result_lane, result_cycles,
                     e.found, e.err, e.lane, e.cycles);
        end
        accept_result("exhausted");
    endtask

    task automatic test_malformed();
        logic [63:0] frames [3];
        int          lens   [3];
        int          s0;
        frames[0] = 64'h6162;       lens[0] = 2;
        frames[1] = 64'h6162636465; lens[1] = 5;
        frames[2] = 64'h61423132;   lens[2] = 4;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back('{found: 1'b0, err: 1'b1, lane: 4'd0, cycles: 32'd0});
            s0 = start_cnt;
            send_frame(frames[k], lens[k]);
            e = exp_q.pop_front();
            checks++;
            if ({result_valid, lane_abort, result_found, result_err} !== {1'b1, 1'b1, e.found, e.err}) begin
                errors++;
                $display("FAIL malformed%0d_result rv=%b ab=%b f=%b e=%b want 1 1 %b %b",
                         k, result_valid, lane_abort, result_found, result_err, e.found, e.err);
            end
            checks++;
            if (start_cnt - s0 !== 0) begin
                errors++;
                $display("FAIL malformed%0d_start_pulses got %0d want 0", k, start_cnt - s0);
            end
            accept_result("malformed");
        end
    endtask

    task automatic test_simultaneous();
        exp_q.push_back('{found: 1'b1, err: 1'b0, lane: 4'd4, cycles: 32'd3});
        send_frame(64'h6B657930, 4);
        repeat (3) tick();
        lane_found = 9'b010010000;
        lane_done  = '1;
        tick();
        lane_found = '0;
        lane_done  = '0;
        e = exp_q.pop_front();
        checks++;
        if ({result_valid, result_found, result_err, result_lane, result_cycles} !==
            {1'b1, e.found, e.err, e.lane, e.cycles}) begin
            errors++;
            $display("FAIL simultaneous_result rv=%b f=%b e=%b l=%0d c=%0d want 1 %b %b %0d %0d",
                     result_valid, result_found, result_err, result_lane, result_cycles,
                     e.found, e.err, e.lane, e.cycles);
        end
        accept_result("simultaneous");
    endtask

    task automatic test_backpressure();
        exp_q.push_back('{found: 1'b1, err: 1'b0, lane: 4'd0, cycles: 32'd2});
        send_frame(64'h70617373, 4);
        repeat (2) tick();
        lane_found = 9'b000000001;
        tick();
        lane_found = '0;
        in_valid = 1'b1;
        in_data  = 8'h41;
        e = exp_q.pop_front();
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({result_valid, in_ready, result_found, result_err, result_lane, result_cycles} !==
                {1'b1, 1'b0, e.found, e.err, e.lane, e.cycles}) begin
                errors++;
                $display("FAIL backpressure_hold%0d rv=%b rdy=%b f=%b e=%b l=%0d c=%0d want 1 0 %b %b %0d %0d",
                         c, result_valid, in_ready, result_found, result_err, result_lane, result_cycles,
                         e.found, e.err, e.lane, e.cycles);
            end
            tick();
        end
        in_valid = 1'b0;
        accept_result("backpressure");
        checks++;
        if (password_to_crack !== 32'h70617373) begin
            errors++;
            $display("FAIL backpressure_pw_hold got %h want 70617373", password_to_crack);
        end
        exp_q.push_back('{found: 1'b0, err: 1'b0, lane: 4'd0, cycles: 32'd1});
        send_frame(64'h31323334, 4);
        checks++;
        if ({lane_start, password_to_crack} !== {1'b1, 32'h31323334}) begin
            errors++;
            $display("FAIL second_frame_start start=%b pw=%h want 1 31323334", lane_start, password_to_crack);
        end
        tick();
        lane_done = '1;
        tick();
        lane_done = '0;
        e = exp_q.pop_front();
        checks++;
        if ({result_valid, result_found, result_err, result_lane, result_cycles} !==
            {1'b1, e.found, e.err, e.lane, e.cycles}) begin
            errors++;
            $display("FAIL second_frame_result rv=%b f=%b e=%b l=%0d c=%0d want 1 %b %b %0d %0d",
                     result_valid, result_found, result_err, result_lane, result_cycles,
                     e.found, e.err, e.lane, e.cycles);
        end
        accept_result("second_frame");
    endtask

    task automatic test_reset_mid_run();
        send_frame(64'h71397139, 4);
        repeat (4) tick();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({lane_start, lane_abort, busy, result_valid, result_found, result_err, result_lane,
             result_cycles, password_to_crack} !== '0) begin
            errors++;
            $display("FAIL midrun_reset got start=%b abort=%b busy=%b rv=%b f=%b e=%b l=%0d c=%0d pw=%h want all 0",
                     lane_start, lane_abort, busy, result_valid, result_found, result_err,
                     result_lane, result_cycles, password_to_crack);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        exp_q.push_back('{found: 1'b1, err: 1'b0, lane: 4'd8, cycles: 32'd6});
        send_frame(64'h6D6E6F70, 4);
        checks++;
        if ({lane_start, password_to_crack} !== {1'b1, 32'h6D6E6F70}) begin
            errors++;
            $display("FAIL after_reset_start start=%b pw=%h want 1 6d6e6f70", lane_start, password_to_crack);
        end
        repeat (6) tick();
        lane_found = 9'b100000000;
        tick();
        lane_found = '0;
        e = exp_q.pop_front();
        checks++;
        if ({result_valid, result_found, result_err, result_lane, result_cycles} !==
            {1'b1, e.found, e.err, e.lane, e.cycles}) begin
            errors++;
            $display("FAIL after_reset_result rv=%b f=%b e=%b l=%0d c=%0d want 1 %b %b %0d %0d",
                     result_valid, result_found, result_err, result_lane, result_cycles,
                     e.found, e.err, e.lane, e.cycles);
        end
        accept_result("after_reset");
    endtask

    initial begin
        test_reset();
        test_match();
        test_exhausted();
        test_malformed();
        test_simultaneous();
        test_backpressure();
        test_reset_mid_run();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
